// File: rtl/left_rotate_seq_if.sv
// Request/response bundle for the sequential left rotate/shift unit.
// The master drives the operands and start; the slave returns result, busy and done.
interface left_rotate_seq_if #(
    parameter int DATA_W = 16,
    parameter int STAGES = 4
);
    logic              start;
    logic [DATA_W-1:0] in;
    logic [STAGES-1:0] cnt;
    logic              op;
    logic [DATA_W-1:0] out;
    logic              busy;
    logic              done;

    modport master (output start, in, cnt, op, input out, busy, done);
    modport slave  (input start, in, cnt, op, output out, busy, done);
endinterface

// File: rtl/left_rotate_seq.sv
// Sequential 16-bit left rotate / logical left shift using four power-of-two steps.
// Latency is fixed at four steps regardless of the amount, followed by a one-cycle done state.
module left_rotate_seq #(
    parameter int DATA_W = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    left_rotate_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, STEP0, STEP1, STEP2, STEP3, DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] work;
    logic [DATA_W-1:0] out_q;
    logic [STAGES-1:0] cnt_q;
    logic              op_q;
    logic              accept;

    // One stage: move by amt positions when enabled; shl selects zero fill over wrap-around.
    function automatic logic [DATA_W-1:0] step_fn(input logic [DATA_W-1:0] v, input int amt,
                                                  input logic en, input logic shl);
        logic [DATA_W-1:0] r;
        if (!en)
            r = v;
        else if (shl)
            r = v << amt;
        else
            r = (v << amt) | (v >> (DATA_W - amt));
        return r;
    endfunction

    assign accept = bus.start && (state == IDLE || state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = STEP0;
            STEP0:   state_nxt = STEP1;
            STEP1:   state_nxt = STEP2;
            STEP2:   state_nxt = STEP3;
            STEP3:   state_nxt = DONE;
            DONE:    state_nxt = bus.start ? STEP0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            work  <= '0;
            out_q <= '0;
            cnt_q <= '0;
            op_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                work  <= bus.in;
                cnt_q <= bus.cnt;
                op_q  <= bus.op;
            end else begin
                case (state)
                    STEP0: work <= step_fn(work, 1, cnt_q[0], op_q);
                    STEP1: work <= step_fn(work, 2, cnt_q[1], op_q);
                    STEP2: work <= step_fn(work, 4, cnt_q[2], op_q);
                    STEP3: begin
                        // Final stage result goes straight to the output register.
                        work  <= step_fn(work, 8, cnt_q[3], op_q);
                        out_q <= step_fn(work, 8, cnt_q[3], op_q);
                    end
                    default: work <= work;
                endcase
            end
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = (state == STEP0) || (state == STEP1) || (state == STEP2) || (state == STEP3);
    assign bus.done = (state == DONE);
endmodule
